// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply / divide unit. One radix-2 step per cycle.
// MUL is shift-add, DIV is restoring. Fixed latency for both operations.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            op,
  input  logic [XLEN-1:0] X,
  input  logic [XLEN-1:0] Y,
  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [XLEN-1:0] result2
);

  localparam int CW = $clog2(XLEN) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state;
  logic [CW-1:0]     cnt;
  logic              op_q;
  logic [XLEN-1:0]   a;    // multiplicand, or dividend shifting out / quotient shifting in
  logic [XLEN-1:0]   b;    // multiplier shifting right, or divisor
  logic [2*XLEN-1:0] acc;  // product, or remainder in the low XLEN+1 bits

  logic            accept;
  logic            term;
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   shifted;
  logic [XLEN+1:0] diff;
  logic            borrow;

  assign accept  = start && (state != S_RUN);
  assign term    = (cnt == CW'(XLEN));

  // Add into the upper half, then shift the whole accumulator right by one.
  assign mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (b[0] ? a : '0)};

  // Trial subtraction with an extra bit so a borrow is visible in the MSB.
  assign shifted = {acc[XLEN-1:0], a[XLEN-1]};
  assign diff    = {1'b0, shifted} - {2'b00, b};
  assign borrow  = diff[XLEN+1];

  assign ready = (state != S_RUN);
  assign busy  = (state == S_RUN);
  assign done  = (state == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      op_q    <= 1'b0;
      a       <= '0;
      b       <= '0;
      acc     <= '0;
      result  <= '0;
      result2 <= '0;
    end else if (accept) begin
      state <= S_RUN;
      op_q  <= op;
      a     <= X;
      b     <= Y;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        S_RUN: begin
          if (term) begin
            state <= S_DONE;
            if (op_q) begin
              result  <= a;
              result2 <= acc[XLEN-1:0];
            end else begin
              result  <= acc[XLEN-1:0];
              result2 <= acc[2*XLEN-1:XLEN];
            end
          end else begin
            cnt <= cnt + CW'(1);
            if (op_q) begin
              // Divide by zero falls out naturally: no step ever borrows.
              acc <= {{(XLEN-1){1'b0}}, (borrow ? shifted : diff[XLEN:0])};
              a   <= {a[XLEN-2:0], ~borrow};
            end else begin
              acc <= {mul_sum, acc[XLEN-1:1]};
              b   <= b >> 1;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
